multicycle_ctrl: RTL and testbench

Multi-cycle stage sequencer that replaces the fixed five-phase stage counter of the single-cycle core. It walks each instruction through IF/ID/EX/MEM/WB using only the stages that instruction needs. It handshakes with variable-latency instruction and data memories, supports external stall, and faults on bus timeout. It drives the stage-enable inputs of the existing pc, decoder, ALU, mem and regfile blocks.

---
 rtl/multicycle_ctrl_pkg.sv | 23 ++
 rtl/multicycle_ctrl_wait_timer.sv | 39 +++
 rtl/multicycle_ctrl.sv | 154 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and constants for the multi-cycle stage sequencer.
// Stage encodings match the debug values exported on the state port.
package multicycle_ctrl_pkg;

  localparam int WORD_WIDTH = 32;
  localparam int STG_W      = 3;

  typedef enum logic [STG_W-1:0] {
    STG_IDLE  = 3'd0,
    STG_IF    = 3'd1,
    STG_ID    = 3'd2,
    STG_EX    = 3'd3,
    STG_MEM   = 3'd4,
    STG_WB    = 3'd5,
    STG_FAULT = 3'd6
  } stg_e;

  // True for the states that hold a bus request open and run the wait timer.
  function automatic logic is_bus_wait(input stg_e s);
    return (s == STG_IF) || (s == STG_MEM);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_wait_timer.sv
// Wait-cycle counter shared by the fetch and data-access handshakes.
// limit is high in the 2^TIMEOUT_W-th consecutive unacked cycle.
module wait_timer #(
  parameter int TIMEOUT_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic cnt_en,
  output logic limit
);

  logic [TIMEOUT_W-1:0] cnt_q;
  logic [TIMEOUT_W-1:0] cnt_d;

  // Next count: clear wins over counting.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_en) begin
      cnt_d = cnt_q + TIMEOUT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign limit = &cnt_q;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle stage sequencer: walks each instruction through only the stages
// it needs, handshaking with variable-latency memories and faulting on timeout.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int W         = WORD_WIDTH,
  parameter int TIMEOUT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             stall,
  input  logic             need_mem,
  input  logic             need_wb,
  output logic             if_req,
  input  logic             if_ack,
  output logic             mem_req,
  input  logic             mem_ack,
  output logic             if_en,
  output logic             id_en,
  output logic             ex_en,
  output logic             mem_en,
  output logic             wb_en,
  output logic             retired,
  output logic [W-1:0]     retire_cnt,
  output logic             bus_err,
  output logic [STG_W-1:0] state
);

  stg_e           state_q, state_d;
  logic           need_mem_q, need_mem_d;
  logic           need_wb_q, need_wb_d;
  logic [W-1:0]   retire_cnt_q, retire_cnt_d;
  logic           tmr_clr_s, tmr_cnt_en_s, tmr_limit_s;

  wait_timer #(.TIMEOUT_W(TIMEOUT_W)) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmr_clr_s),
    .cnt_en (tmr_cnt_en_s),
    .limit  (tmr_limit_s)
  );

  // Next-state and Mealy stage enables; retire is resolved after the case.
  always_comb begin
    state_d    = state_q;
    need_mem_d = need_mem_q;
    need_wb_d  = need_wb_q;
    if_en      = 1'b0;
    id_en      = 1'b0;
    ex_en      = 1'b0;
    mem_en     = 1'b0;
    wb_en      = 1'b0;
    retired    = 1'b0;
    case (state_q)
      STG_IDLE: begin
        if (en) state_d = STG_IF;
        else    state_d = STG_IDLE;
      end
      STG_IF: begin
        if (if_ack) begin
          if_en   = 1'b1;
          state_d = STG_ID;
        end else if (tmr_limit_s) begin
          state_d = STG_FAULT;
        end else begin
          state_d = STG_IF;
        end
      end
      STG_ID: begin
        if (!stall) begin
          id_en      = 1'b1;
          need_mem_d = need_mem;
          need_wb_d  = need_wb;
          state_d    = STG_EX;
        end else begin
          state_d = STG_ID;
        end
      end
      STG_EX: begin
        if (!stall) begin
          ex_en = 1'b1;
          if (need_mem_q)     state_d = STG_MEM;
          else if (need_wb_q) state_d = STG_WB;
          else                retired = 1'b1;
        end else begin
          state_d = STG_EX;
        end
      end
      STG_MEM: begin
        // An ack in the limit cycle still completes the access.
        if (mem_ack) begin
          mem_en = 1'b1;
          if (need_wb_q) state_d = STG_WB;
          else           retired = 1'b1;
        end else if (tmr_limit_s) begin
          state_d = STG_FAULT;
        end else begin
          state_d = STG_MEM;
        end
      end
      STG_WB: begin
        if (!stall) begin
          wb_en   = 1'b1;
          retired = 1'b1;
        end else begin
          state_d = STG_WB;
        end
      end
      default: begin
        state_d = STG_FAULT;
      end
    endcase
    if (retired) begin
      state_d = en ? STG_IF : STG_IDLE;
    end else begin
      state_d = state_d;
    end
  end

  // Wait timer control and retire counter update.
  always_comb begin
    tmr_clr_s    = is_bus_wait(state_d) && (state_d != state_q);
    tmr_cnt_en_s = ((state_q == STG_IF) && !if_ack) ||
                   ((state_q == STG_MEM) && !mem_ack);
    if (retired) begin
      retire_cnt_d = retire_cnt_q + W'(1);
    end else begin
      retire_cnt_d = retire_cnt_q;
    end
  end

  // Sequencer state, decoder-need latches and retire count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= STG_IDLE;
      need_mem_q   <= 1'b0;
      need_wb_q    <= 1'b0;
      retire_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      need_mem_q   <= need_mem_d;
      need_wb_q    <= need_wb_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign if_req     = (state_q == STG_IF);
  assign mem_req    = (state_q == STG_MEM);
  assign bus_err    = (state_q == STG_FAULT);
  assign state      = state_q;
  assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboarded bench: stimulus queues expected stage-enable events, a monitor
// pops and compares them whenever the controller emits an enable or retire.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0, stall = 1'b0, need_mem = 1'b0, need_wb = 1'b0;
  logic        if_ack = 1'b0, mem_ack = 1'b0;
  logic        if_req, mem_req, if_en, id_en, ex_en, mem_en, wb_en, retired, bus_err;
  logic [31:0] retire_cnt;
  logic [2:0]  state;

  int total = 0;
  int bad   = 0;
  logic [5:0] exp_q[$];

  multicycle_ctrl #(.W(32), .TIMEOUT_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .stall(stall), .need_mem(need_mem),
    .need_wb(need_wb), .if_req(if_req), .if_ack(if_ack), .mem_req(mem_req),
    .mem_ack(mem_ack), .if_en(if_en), .id_en(id_en), .ex_en(ex_en),
    .mem_en(mem_en), .wb_en(wb_en), .retired(retired),
    .retire_cnt(retire_cnt), .bus_err(bus_err), .state(state)
  );

  always #5 clk = ~clk;

  // Event codes: {if_en, id_en, ex_en, mem_en, wb_en, retired}
  localparam logic [5:0] E_IF  = 6'b100000;
  localparam logic [5:0] E_ID  = 6'b010000;
  localparam logic [5:0] E_EX  = 6'b001000;
  localparam logic [5:0] E_MEM = 6'b000100;
  localparam logic [5:0] E_WBR = 6'b000011;
  localparam logic [5:0] E_EXR = 6'b001001;
  localparam logic [5:0] E_MMR = 6'b000101;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every cycle with any enable/retire consumes one expected event.
  always @(negedge clk) begin
    logic [5:0] ev;
    logic [5:0] e;
    ev = {if_en, id_en, ex_en, mem_en, wb_en, retired};
    if (rst && ev != 6'b0) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event: got %b expected none", ev);
      end else begin
        e = exp_q.pop_front();
        if (ev !== e) begin
          bad++;
          $display("FAIL event: got %b expected %b", ev, e);
        end
      end
    end
  end

  // One clock: drive inputs, let the edge pass, check the new state.
  task automatic step(input logic e, input logic s, input logic nm, input logic nw,
                      input logic ia, input logic ma, input logic [2:0] exp, input string name);
    en = e; stall = s; need_mem = nm; need_wb = nw; if_ack = ia; mem_ack = ma;
    @(negedge clk);
    @(posedge clk);
    #1;
    chk(name, {29'd0, state}, {29'd0, exp});
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", {29'd0, state}, {29'd0, STG_IDLE});
    chk("rst_reqs", {30'd0, if_req, mem_req}, 32'd0);
    chk("rst_cnt", retire_cnt, 32'd0);
    chk("rst_buserr", {31'd0, bus_err}, 32'd0);
    rst = 1'b1;

    // ALU op, zero-wait fetch
    step(1, 0, 0, 0, 0, 0, STG_IF, "alu_idle");
    exp_q.push_back(E_IF);  step(1, 0, 0, 1, 1, 0, STG_ID, "alu_if");
    exp_q.push_back(E_ID);  step(1, 0, 0, 1, 0, 0, STG_EX, "alu_id");
    exp_q.push_back(E_EX);  step(1, 0, 0, 0, 0, 0, STG_WB, "alu_ex");
    exp_q.push_back(E_WBR); step(1, 0, 0, 0, 0, 0, STG_IF, "alu_wb");
    chk("alu_cnt", retire_cnt, 32'd1);
    chk("alu_next_ifreq", {31'd0, if_req}, 32'd1);

    // Load with mem_ack after 3 wait cycles
    exp_q.push_back(E_IF);  step(1, 0, 1, 1, 1, 0, STG_ID, "ld_if");
    exp_q.push_back(E_ID);  step(1, 0, 1, 1, 0, 0, STG_EX, "ld_id");
    exp_q.push_back(E_EX);  step(1, 0, 0, 0, 0, 0, STG_MEM, "ld_ex");
    for (int i = 0; i < 3; i++) begin
      chk("ld_memreq", {31'd0, mem_req}, 32'd1);
      step(1, 1, 0, 0, 1, 0, STG_MEM, "ld_wait");
    end
    exp_q.push_back(E_MEM); step(1, 0, 0, 0, 0, 1, STG_WB, "ld_ack");
    exp_q.push_back(E_WBR); step(1, 0, 0, 0, 0, 0, STG_IF, "ld_wb");
    chk("ld_cnt", retire_cnt, 32'd2);

    // Branch with two stalled EX cycles
    exp_q.push_back(E_IF);  step(1, 0, 0, 0, 1, 0, STG_ID, "br_if");
    exp_q.push_back(E_ID);  step(1, 0, 0, 0, 0, 0, STG_EX, "br_id");
    step(1, 1, 0, 0, 0, 0, STG_EX, "br_stall1");
    step(1, 1, 0, 0, 0, 0, STG_EX, "br_stall2");
    exp_q.push_back(E_EXR); step(1, 0, 0, 0, 0, 0, STG_IF, "br_ex");
    chk("br_cnt", retire_cnt, 32'd3);

    // Store, en dropped during MEM
    exp_q.push_back(E_IF);  step(1, 0, 1, 0, 1, 0, STG_ID, "st_if");
    exp_q.push_back(E_ID);  step(1, 0, 1, 0, 0, 0, STG_EX, "st_id");
    exp_q.push_back(E_EX);  step(1, 0, 0, 0, 0, 0, STG_MEM, "st_ex");
    step(0, 0, 0, 0, 0, 0, STG_MEM, "st_wait");
    exp_q.push_back(E_MMR); step(0, 0, 0, 0, 0, 1, STG_IDLE, "st_ack");
    chk("st_cnt", retire_cnt, 32'd4);
    step(1, 0, 0, 0, 0, 0, STG_IF, "st_reen");

    // Fetch ack in the 16th waiting cycle still proceeds; stalls in ID and WB
    for (int i = 0; i < 15; i++) step(1, 0, 0, 0, 0, 1, STG_IF, "lim_wait");
    exp_q.push_back(E_IF);  step(1, 0, 0, 0, 1, 0, STG_ID, "lim_ack");
    step(1, 1, 0, 0, 1, 1, STG_ID, "id_stall");
    exp_q.push_back(E_ID);  step(1, 0, 0, 1, 0, 0, STG_EX, "lim_id");
    exp_q.push_back(E_EX);  step(1, 0, 0, 0, 0, 0, STG_WB, "lim_ex");
    step(1, 1, 0, 0, 0, 0, STG_WB, "wb_stall");
    exp_q.push_back(E_WBR); step(0, 0, 0, 0, 0, 0, STG_IDLE, "lim_wb");
    chk("lim_cnt", retire_cnt, 32'd5);

    // Asynchronous reset in the middle of MEM
    step(1, 0, 0, 0, 0, 0, STG_IF, "rs_idle");
    exp_q.push_back(E_IF);  step(1, 0, 1, 1, 1, 0, STG_ID, "rs_if");
    exp_q.push_back(E_ID);  step(1, 0, 1, 1, 0, 0, STG_EX, "rs_id");
    exp_q.push_back(E_EX);  step(1, 0, 0, 0, 0, 0, STG_MEM, "rs_ex");
    chk("rs_memreq", {31'd0, mem_req}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rs_state", {29'd0, state}, {29'd0, STG_IDLE});
    chk("rs_memreq0", {31'd0, mem_req}, 32'd0);
    chk("rs_cnt", retire_cnt, 32'd0);
    #2 rst = 1'b1;
    step(1, 0, 0, 0, 0, 0, STG_IF, "rs_restart");
    exp_q.push_back(E_IF);  step(1, 0, 0, 1, 1, 0, STG_ID, "rs2_if");
    exp_q.push_back(E_ID);  step(1, 0, 0, 1, 0, 0, STG_EX, "rs2_id");
    exp_q.push_back(E_EX);  step(1, 0, 0, 0, 0, 0, STG_WB, "rs2_ex");
    exp_q.push_back(E_WBR); step(1, 0, 0, 0, 0, 0, STG_IF, "rs2_wb");
    chk("rs2_cnt", retire_cnt, 32'd1);

    // Fetch timeout: 16 unacked IF cycles end in FAULT
    for (int i = 0; i < 15; i++) step(1, 0, 0, 0, 0, 1, STG_IF, "to_wait");
    step(1, 0, 0, 0, 0, 0, STG_FAULT, "to_fault");
    chk("to_buserr", {31'd0, bus_err}, 32'd1);
    chk("to_reqs", {30'd0, if_req, mem_req}, 32'd0);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 1, 1, 1, STG_FAULT, "to_absorb");
    chk("to_cnt", retire_cnt, 32'd1);
    chk("to_buserr2", {31'd0, bus_err}, 32'd1);

    @(negedge clk);
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
